// File: rtl/seg7_scan_driver_if.sv
// Display-side signal bundle for the seven-segment scan driver: data/control
// from the datapath (master) and the scanned board outputs from the driver (slave).
interface seg7_scan_driver_if;
    logic [31:0] value;
    logic        load;
    logic        half_sel;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        slot_tick;

    modport master (
        output value, load, half_sel, blank_lz,
        input  an, seg, dp, slot_tick
    );

    modport slave (
        input  value, load, half_sel, blank_lz,
        output an, seg, dp, slot_tick
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode hex display scanner: shadows a 32-bit result, shows one
// 16-bit half, inserts an all-off guard at each slot start, optional leading-zero blanking.
module seg7_scan_driver #(
    parameter int DIV_W = 16,
    parameter int GUARD = 4
) (
    input  logic           clk,
    input  logic           reset,
    seg7_scan_driver_if.slave disp
);

    logic [DIV_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       idx_reg, idx_next;
    logic [31:0]      shadow_reg, shadow_next;
    logic [3:0]       an_reg, an_next;
    logic [6:0]       seg_reg, seg_next;
    logic             dp_reg, dp_next;
    logic             tick_reg, tick_next;

    logic [15:0]      half_word;
    logic [3:0]       nibble [4];
    logic [3:0]       nib_zero;
    logic [3:0]       zero_from;
    logic [3:0]       cur_nib;
    logic             cur_blank;
    logic             guard_active;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign half_word = disp.half_sel ? shadow_reg[31:16] : shadow_reg[15:0];

    // zero_from[k] is set when every nibble from position k up to 3 is zero,
    // which is exactly the leading-zero condition for digit k.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nib
            assign nibble[gi]   = half_word[4*gi +: 4];
            assign nib_zero[gi] = (half_word[4*gi +: 4] == 4'h0);
            if (gi == 3) begin : g_top
                assign zero_from[gi] = nib_zero[gi];
            end else begin : g_chain
                assign zero_from[gi] = nib_zero[gi] & zero_from[gi+1];
            end
        end
    endgenerate

    // A zero-length guard must never force the anodes off.
    generate
        if (GUARD == 0) begin : g_no_guard
            assign guard_active = 1'b0;
        end else begin : g_guard
            localparam logic [DIV_W-1:0] GUARD_CNT = DIV_W'(GUARD);
            assign guard_active = (cnt_reg < GUARD_CNT);
        end
    endgenerate

    assign cur_nib   = nibble[idx_reg];
    assign cur_blank = disp.blank_lz && (idx_reg != 2'd0) && zero_from[idx_reg];

    always_comb begin
        cnt_next    = cnt_reg + 1'b1;
        idx_next    = idx_reg;
        shadow_next = shadow_reg;
        tick_next   = 1'b0;
        an_next     = 4'b1111;
        seg_next    = 7'b1111111;
        dp_next     = 1'b1;

        if (cnt_reg == {DIV_W{1'b1}}) begin
            idx_next  = idx_reg + 2'd1;
            tick_next = 1'b1;
        end

        if (disp.load) begin
            shadow_next = disp.value;
        end

        if (!guard_active) begin
            an_next = ~(4'b0001 << idx_reg);
        end

        if (!cur_blank) begin
            seg_next = hex_to_seg(cur_nib);
            dp_next  = ~(disp.half_sel && (idx_reg == 2'd3));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg    <= '0;
            idx_reg    <= 2'd0;
            shadow_reg <= 32'h0;
            an_reg     <= 4'b1111;
            seg_reg    <= 7'b1111111;
            dp_reg     <= 1'b1;
            tick_reg   <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            idx_reg    <= idx_next;
            shadow_reg <= shadow_next;
            an_reg     <= an_next;
            seg_reg    <= seg_next;
            dp_reg     <= dp_next;
            tick_reg   <= tick_next;
        end
    end

    assign disp.an        = an_reg;
    assign disp.seg       = seg_reg;
    assign disp.dp        = dp_reg;
    assign disp.slot_tick = tick_reg;

endmodule
